// File: rtl/gate_pkg.sv
// Shared definitions for the gate exerciser family.
//   OP_* : gate type encoding carried on the 3-bit op bus
//   state_e : exerciser FSM states
//   gate_eval(op, vec, width) : golden output of a width-input gate
package gate_pkg;

  localparam int MAX_W = 16;

  localparam logic [2:0] OP_BUF  = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Reductions only span the low 'width' bits; for width == 1 they
  // collapse onto vec[0], so AND/OR/XOR act as BUF and the inverted
  // forms as NOT without a special case.
  function automatic logic gate_eval(input logic [2:0] op,
                                     input logic [MAX_W-1:0] vec,
                                     input int width);
    logic r_and, r_or, r_xor;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        r_and = r_and & vec[i];
        r_or  = r_or  | vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (op)
      OP_BUF:  gate_eval = vec[0];
      OP_NOT:  gate_eval = ~vec[0];
      OP_AND:  gate_eval = r_and;
      OP_NAND: gate_eval = ~r_and;
      OP_OR:   gate_eval = r_or;
      OP_NOR:  gate_eval = ~r_or;
      OP_XOR:  gate_eval = r_xor;
      default: gate_eval = ~r_xor;
    endcase
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model for a WIDTH-input gate.
//   op  : gate type (gate_pkg OP_* encoding)
//   vec : gate input vector
//   y   : expected gate output
module gate_ref_model
  import gate_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] vec,
  output logic             y
);

  logic [MAX_W-1:0] vec_ext;

  assign vec_ext = MAX_W'(vec);
  assign y       = gate_eval(op, vec_ext, WIDTH);

endmodule

// File: rtl/gate_exerciser.sv
// Clocked stimulus generator and checker for single-output gate DUTs.
// Sweeps all 2^WIDTH input vectors PASSES times, two cycles per vector
// (DRIVE lets the DUT settle, CHECK compares against the golden model).
//   clk, reset    : clock, synchronous active-high reset
//   start, op     : run request and gate type (latched on accepted start)
//   stim          : registered DUT input vector
//   dut_out       : DUT response to stim
//   busy, done    : run in progress / run finished
//   pass          : no mismatches in the finished run
//   err_pulse     : one cycle per mismatch, aligned with err_count update
//   err_count     : saturating mismatch count
//   first_err_vec : stim of the first mismatch, 0 if none
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int PASSES = 4,
  parameter int ECW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [ECW-1:0]   err_count,
  output logic [WIDTH-1:0] first_err_vec
);

  localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [ECW-1:0]   err_count_q, err_count_d;
  logic [WIDTH-1:0] first_err_q, first_err_d;
  logic             err_pulse_q, err_pulse_d;
  logic             golden;

  gate_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op  (op_q),
    .vec (stim_q),
    .y   (golden)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    stim_d      = stim_q;
    pass_cnt_d  = pass_cnt_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    err_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_DRIVE;
          op_d        = op;
          stim_d      = '0;
          pass_cnt_d  = '0;
          err_count_d = '0;
          first_err_d = '0;
        end
      end
      ST_DRIVE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (dut_out != golden) begin
          err_pulse_d = 1'b1;
          if (err_count_q != '1) err_count_d = err_count_q + ECW'(1);
          // A zero count means nothing has failed yet this run.
          if (err_count_q == '0) first_err_d = stim_q;
        end
        if (stim_q != '1) begin
          stim_d  = stim_q + WIDTH'(1);
          state_d = ST_DRIVE;
        end else if (pass_cnt_q != LAST_PASS) begin
          pass_cnt_d = pass_cnt_q + 8'd1;
          stim_d     = '0;
          state_d    = ST_DRIVE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      stim_q      <= '0;
      pass_cnt_q  <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      stim_q      <= stim_d;
      pass_cnt_q  <= pass_cnt_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign stim          = stim_q;
  assign busy          = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
  assign done          = (state_q == ST_DONE);
  assign pass          = done && (err_count_q == '0);
  assign err_pulse     = err_pulse_q;
  assign err_count     = err_count_q;
  assign first_err_vec = first_err_q;

endmodule

// File: tb/tb_gate_exerciser.sv
module tb_gate_exerciser;

  localparam int W = 3;
  localparam int P = 2;
  localparam int E = 3;
  localparam int NV = 1 << W;

  typedef struct {
    int cnt;
    int first;
    int pass;
  } result_t;

  logic clk, reset, start, dut_out, busy, done, pass, err_pulse;
  logic [2:0] op;
  logic [W-1:0] stim, first_err_vec;
  logic [E-1:0] err_count;

  // second instance: single-input degenerate case
  logic start1, dut1_out, busy1, done1, pass1, err_pulse1, bad1;
  logic [0:0] stim1, first1;
  logic [7:0] err_count1;

  int checks = 0;
  int failures = 0;

  int exp_stim_q[$];
  bit exp_err_q[$];
  result_t exp_res_q[$];

  int run_op;
  bit [NV-1:0] flip_mask;

  // Reference gate: defined by the number of ones in the vector.
  function automatic bit tb_gold(int o, int v, int w);
    int ones;
    ones = $countones(v & ((1 << w) - 1));
    case (o)
      0: return v[0];
      1: return !v[0];
      2: return ones == w;
      3: return ones != w;
      4: return ones > 0;
      5: return ones == 0;
      6: return ones % 2 == 1;
      default: return ones % 2 == 0;
    endcase
  endfunction

  assign dut_out  = tb_gold(run_op, int'(stim), W) ^ flip_mask[stim];
  assign dut1_out = bad1 ? stim1[0] : !stim1[0];

  gate_exerciser #(.WIDTH(W), .PASSES(P), .ECW(E)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .stim(stim),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_pulse(err_pulse), .err_count(err_count), .first_err_vec(first_err_vec)
  );

  gate_exerciser #(.WIDTH(1), .PASSES(4), .ECW(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(3'd1), .stim(stim1),
    .dut_out(dut1_out), .busy(busy1), .done(done1), .pass(pass1),
    .err_pulse(err_pulse1), .err_count(err_count1), .first_err_vec(first1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops expected stimulus per vector, expected error pulse per
  // CHECK, and the expected verdict when done rises.
  initial begin
    int phase, cur;
    bit pend_v, pend, done_prev;
    result_t r;
    phase = 0; cur = 0; pend_v = 0; pend = 0; done_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        phase = 0; pend_v = 0; done_prev = 0;
        continue;
      end
      if (pend_v) begin
        chk("err_pulse", int'(err_pulse), int'(pend));
        pend_v = 0;
      end else if (err_pulse) begin
        chk("err_pulse_spurious", 1, 0);
      end
      if (busy) begin
        if (phase == 0) begin
          if (exp_stim_q.size() == 0) begin
            chk("stim_unexpected", int'(stim), -1);
            cur = -1;
          end else begin
            cur = exp_stim_q.pop_front();
            chk("stim_drive", int'(stim), cur);
          end
          phase = 1;
        end else begin
          chk("stim_check", int'(stim), cur);
          if (exp_err_q.size() != 0) begin
            pend = exp_err_q.pop_front();
            pend_v = 1;
          end
          phase = 0;
        end
      end
      if (done && !done_prev) begin
        if (exp_res_q.size() == 0) begin
          chk("result_unexpected", 1, 0);
        end else begin
          r = exp_res_q.pop_front();
          chk("err_count", int'(err_count), r.cnt);
          chk("first_err_vec", int'(first_err_vec), r.first);
          chk("pass", int'(pass), r.pass);
          chk("stim_queue_empty", exp_stim_q.size(), 0);
        end
      end
      done_prev = done;
    end
  end

  // mode: 0 good, 1 inverted, 2 stuck-at-0, 3 random flips
  task automatic prepare(input int o, input int mode);
    int errs, first;
    result_t r;
    run_op = o;
    for (int v = 0; v < NV; v++) begin
      case (mode)
        0: flip_mask[v] = 1'b0;
        1: flip_mask[v] = 1'b1;
        2: flip_mask[v] = tb_gold(o, v, W);
        default: flip_mask[v] = 1'($urandom_range(0, 3) == 0);
      endcase
    end
    errs = 0; first = -1;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < NV; v++) begin
        exp_stim_q.push_back(v);
        exp_err_q.push_back(flip_mask[v]);
        if (flip_mask[v]) begin
          errs++;
          if (first < 0) first = v;
        end
      end
    r.cnt = (errs > (1 << E) - 1) ? (1 << E) - 1 : errs;
    r.first = (first < 0) ? 0 : first;
    r.pass = (errs == 0);
    exp_res_q.push_back(r);
  endtask

  task automatic issue_start(input int o);
    op = 3'(o);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    chk("done_after_start", int'(done), 0);
    chk("stim_after_start", int'(stim), 0);
  endtask

  task automatic wait_done();
    int n, lim;
    n = 1; lim = 0;
    while (!done && lim < 500) begin
      @(negedge clk);
      lim++;
      if (busy) n++;
      // start and op changes mid-run must be ignored
      if (n == 5) begin start = 1'b1; op = ~op; end
      if (n == 6) start = 1'b0;
    end
    start = 1'b0;
    chk("done_reached", int'(done), 1);
    chk("run_cycles", n, 2 * NV * P);
    chk("busy_at_done", int'(busy), 0);
  endtask

  task automatic run(input int o, input int mode);
    prepare(o, mode);
    issue_start(o);
    wait_done();
    tick();
    chk("done_hold", int'(done), 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_stim", int'(stim), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_first_err", int'(first_err_vec), 0);
  endtask

  task automatic run1(input bit bad);
    int n, lim;
    bad1 = bad;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0; lim = 0;
    while (!done1 && lim < 200) begin
      @(negedge clk);
      lim++;
      if (busy1) begin
        chk("w1_stim", int'(stim1), (n / 2) % 2);
        n++;
      end
    end
    chk("w1_done", int'(done1), 1);
    chk("w1_cycles", n, 16);
    chk("w1_err_count", int'(err_count1), bad ? 8 : 0);
    chk("w1_pass", int'(pass1), bad ? 0 : 1);
    chk("w1_first", int'(first1), 0);
    tick();
  endtask

  initial begin
    int lim;
    reset = 1'b1; start = 1'b0; start1 = 1'b0; op = 3'd0;
    run_op = 0; flip_mask = '0; bad1 = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    reset = 1'b0;
    tick();

    run(3, 0);   // NAND, correct DUT
    run(6, 2);   // XOR, stuck-at-0
    run(4, 1);   // OR, inverted: saturates
    run(2, 0);   // AND, correct
    run(0, 1);   // BUF, inverted
    for (int k = 0; k < 6; k++) run(int'($urandom_range(0, 7)), 3);

    // abort a run with reset at vector 2
    prepare(5, 1);
    issue_start(5);
    lim = 0;
    while (stim != 3'd2 && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    chk("abort_reached_vec2", int'(stim), 2);
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals();
    exp_stim_q.delete();
    exp_err_q.delete();
    exp_res_q.delete();
    reset = 1'b0;
    tick();
    run(2, 0);

    run1(1'b0);
    run1(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
